// File: rtl/sram_param_bwe.sv
// Single-port-style SRAM model with separate read/write addresses, byte write enables,
// write-first read-during-write, optional output register and a background clear engine.
module sram_param_bwe #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned OUT_REG = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                csb,
    input  logic                wsb,
    input  logic [DATA_W/8-1:0] wmask,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [ADDR_W-1:0]   raddr,
    input  logic                clr_req,
    output logic                busy,
    output logic [DATA_W-1:0]   rdata,
    output logic                rvalid
);

    localparam int unsigned       NumBytes = DATA_W / 8;
    localparam logic [ADDR_W:0]   DepthCmp = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    typedef enum logic {StIdle, StClear} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic                clr_we;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                waddr_ok, raddr_ok, wr_en, rd_en;
    logic [DATA_W-1:0]   rd_word;
    logic                s1_valid_q;
    logic [DATA_W-1:0]   s1_data_q;
    logic                fin_valid;
    logic [DATA_W-1:0]   fin_data;
    logic                rvalid_q;
    logic [DATA_W-1:0]   rdata_q;

    assign busy     = (state_q == StClear);
    assign waddr_ok = ({1'b0, waddr} < DepthCmp);
    assign raddr_ok = ({1'b0, raddr} < DepthCmp);
    // The array has no reset, so requests are gated here while rst_n is low.
    assign wr_en    = rst_n & ~csb & ~wsb & ~busy & waddr_ok;
    assign rd_en    = rst_n & ~csb & ~busy;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_we    = 1'b0;
        case (state_q)
            StIdle: begin
                if (clr_req) begin
                    state_d   = StClear;
                    clr_cnt_d = '0;
                end
            end
            StClear: begin
                clr_we    = 1'b1;
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                if (clr_cnt_q == LastAddr) begin
                    state_d   = StIdle;
                    clr_cnt_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Write-first: bytes being written this edge bypass into the read word.
    always_comb begin
        rd_word = '0;
        if (raddr_ok) begin
            rd_word = mem[raddr];
        end
        if (wr_en && (waddr == raddr)) begin
            for (int unsigned b = 0; b < NumBytes; b++) begin
                if (wmask[b]) begin
                    rd_word[8*b +: 8] = wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_cnt_q] <= '0;
        end else if (wr_en) begin
            for (int unsigned b = 0; b < NumBytes; b++) begin
                if (wmask[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= rd_en;
            if (rd_en) begin
                s1_data_q <= rd_word;
            end
        end
    end

    assign fin_valid = (OUT_REG != 0) ? s1_valid_q : rd_en;
    assign fin_data  = (OUT_REG != 0) ? s1_data_q  : rd_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= fin_valid;
            if (fin_valid) begin
                rdata_q <= fin_data;
            end
        end
    end

    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;

`ifndef SYNTHESIS
    task automatic load(input logic [ADDR_W-1:0] index, input logic [DATA_W-1:0] data);
        if ({1'b0, index} < DepthCmp) begin
            mem[index] <= data;
        end
    endtask

    task automatic display();
        for (int unsigned i = 0; i < DEPTH; i++) begin
            $display("mem[%0d] = %h", i, mem[i]);
        end
    endtask
`endif

endmodule

// File: tb/tb_sram_param_bwe.sv
// Randomized and directed bench for sram_param_bwe: two instances (full depth with
// OUT_REG=0, DEPTH=48 with OUT_REG=1) share stimulus and are scored against an array model.
module tb_sram_param_bwe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        csb, wsb, clr_req;
    logic [7:0]  wmask;
    logic [63:0] wdata;
    logic [5:0]  waddr, raddr;
    logic [1:0]  busy, rvalid;
    logic [63:0] rdata [2];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model state
    logic [63:0] m_mem   [2][64];
    bit          m_busy  [2];
    int          m_cnt   [2];
    logic [63:0] m_rdata [2];
    bit          sv      [2][4];
    logic [63:0] sd      [2][4];

    always #5 clk = ~clk;

    sram_param_bwe #(.DATA_W(64), .DEPTH(64), .ADDR_W(6), .OUT_REG(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .csb(csb), .wsb(wsb), .wmask(wmask), .wdata(wdata),
        .waddr(waddr), .raddr(raddr), .clr_req(clr_req), .busy(busy[0]),
        .rdata(rdata[0]), .rvalid(rvalid[0])
    );

    sram_param_bwe #(.DATA_W(64), .DEPTH(48), .ADDR_W(6), .OUT_REG(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .csb(csb), .wsb(wsb), .wmask(wmask), .wdata(wdata),
        .waddr(waddr), .raddr(raddr), .clr_req(clr_req), .busy(busy[1]),
        .rdata(rdata[1]), .rvalid(rvalid[1])
    );

    function automatic int dep(int k);
        return (k == 0) ? 64 : 48;
    endfunction

    function automatic int lat(int k);
        return (k == 0) ? 1 : 2;
    endfunction

    function automatic logic [63:0] merge(logic [63:0] old, logic [63:0] nw, logic [7:0] m);
        for (int b = 0; b < 8; b++) begin
            if (m[b]) old[8*b +: 8] = nw[8*b +: 8];
        end
        return old;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic set_idle();
        csb = 1'b1; wsb = 1'b1; clr_req = 1'b0; wmask = 8'h00;
        wdata = 64'h0; waddr = 6'd0; raddr = 6'd0;
    endtask

    // Advance the model by one edge using the inputs currently applied.
    task automatic model_edge();
        int n, slot, ra, wa;
        logic [63:0] rd;
        n  = cyc + 1;
        ra = int'(raddr);
        wa = int'(waddr);
        for (int k = 0; k < 2; k++) begin
            slot = (n + lat(k) - 1) % 4;
            if (!m_busy[k]) begin
                if (!csb) begin
                    rd = (ra < dep(k)) ? m_mem[k][ra] : 64'h0;
                    if (!wsb && wa == ra && ra < dep(k)) rd = merge(rd, wdata, wmask);
                    sv[k][slot] = 1'b1;
                    sd[k][slot] = rd;
                    if (!wsb && wa < dep(k)) m_mem[k][wa] = merge(m_mem[k][wa], wdata, wmask);
                end
                if (clr_req) begin
                    m_busy[k] = 1'b1;
                    m_cnt[k]  = 0;
                end
            end else begin
                m_mem[k][m_cnt[k]] = 64'h0;
                m_cnt[k]++;
                if (m_cnt[k] == dep(k)) m_busy[k] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        int s;
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        s = cyc % 4;
        for (int k = 0; k < 2; k++) begin
            if (sv[k][s]) m_rdata[k] = sd[k][s];
            check_eq($sformatf("rvalid%0d", k), {63'h0, rvalid[k]}, {63'h0, sv[k][s]});
            check_eq($sformatf("rdata%0d", k), rdata[k], m_rdata[k]);
            check_eq($sformatf("busy%0d", k), {63'h0, busy[k]}, {63'h0, m_busy[k]});
            sv[k][s] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 1'b0; m_cnt[k] = 0; m_rdata[k] = 64'h0;
            for (int s = 0; s < 4; s++) sv[k][s] = 1'b0;
            check_eq($sformatf("rst_busy%0d", k), {63'h0, busy[k]}, 64'h0);
            check_eq($sformatf("rst_rvalid%0d", k), {63'h0, rvalid[k]}, 64'h0);
            check_eq($sformatf("rst_rdata%0d", k), rdata[k], 64'h0);
        end
        #2;
        rst_n = 1'b1;
    endtask

    task automatic load_both(input int a, input logic [63:0] d);
        u_dut0.load(6'(a), d);
        m_mem[0][a] = d;
        if (a < 48) begin
            u_dut1.load(6'(a), d);
            m_mem[1][a] = d;
        end
    endtask

    task automatic read_at(input int a);
        csb = 1'b0; wsb = 1'b1; clr_req = 1'b0; raddr = 6'(a);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt;
        set_idle();
        #1;
        do_reset();
        for (int a = 0; a < 64; a++) load_both(a, {$urandom, $urandom});

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            csb     = ($urandom_range(0, 3) == 0);
            wsb     = 1'($urandom_range(0, 1));
            wmask   = 8'($urandom);
            wdata   = {$urandom, $urandom};
            waddr   = 6'($urandom_range(0, 63));
            raddr   = ($urandom_range(0, 3) == 0) ? waddr : 6'($urandom_range(0, 63));
            clr_req = ($urandom_range(0, 59) == 0);
            tick();
            if ($urandom_range(0, 299) == 0) do_reset();
        end
        set_idle();
        do_reset();

        // Masked write then read
        load_both(5, 64'h1111_1111_1111_1111);
        csb = 1'b0; wsb = 1'b0; waddr = 6'd5; wdata = 64'hAAAA_BBBB_CCCC_DDDD; wmask = 8'h0F;
        raddr = 6'd0;
        tick();
        read_at(5);
        check_eq("masked_rd", rdata[0], 64'h1111_1111_CCCC_DDDD);
        check_eq("masked_rvalid", {63'h0, rvalid[0]}, 64'h1);
        set_idle();
        tick();
        check_eq("rvalid_pulse", {63'h0, rvalid[0]}, 64'h0);
        check_eq("rdata_hold", rdata[0], 64'h1111_1111_CCCC_DDDD);
        check_eq("masked_rd_oreg", rdata[1], 64'h1111_1111_CCCC_DDDD);

        // Read during write, same address
        load_both(9, 64'h0);
        csb = 1'b0; wsb = 1'b0; waddr = 6'd9; raddr = 6'd9; wdata = 64'hFF; wmask = 8'h01;
        tick();
        check_eq("rdw_first", rdata[0], 64'h0000_0000_0000_00FF);
        set_idle();
        tick();
        tick();

        // Back-to-back latency through the output register
        for (int a = 0; a < 3; a++) load_both(a, 64'h100 + 64'(a));
        for (int e = 1; e <= 5; e++) begin
            if (e <= 3) begin
                csb = 1'b0; wsb = 1'b1; raddr = 6'(e - 1);
            end else begin
                set_idle();
            end
            tick();
            check_eq($sformatf("oreg_valid_e%0d", e), {63'h0, rvalid[1]},
                     (e >= 2 && e <= 4) ? 64'h1 : 64'h0);
            if (e >= 2 && e <= 4) check_eq($sformatf("oreg_data_e%0d", e), rdata[1],
                                           64'h100 + 64'(e - 2));
        end

        // Full clear with dropped write, ignored re-requests, including the final edge
        for (int a = 0; a < 64; a++) load_both(a, 64'hDEAD);
        set_idle();
        clr_req = 1'b1;
        tick();
        cnt = 0;
        while (busy[0] && cnt < 200) begin
            cnt++;
            set_idle();
            if (cnt == 3) begin
                csb = 1'b0; wsb = 1'b0; waddr = 6'd3; wdata = '1; wmask = 8'hFF;
            end
            if (cnt == 10 || cnt == 64) clr_req = 1'b1;
            tick();
        end
        check_eq("clr_busy_cycles", 64'(cnt), 64'd64);
        set_idle();
        u_dut0.display();
        for (int a = 0; a < 64; a++) begin
            read_at(a);
            check_eq($sformatf("clr_word%0d", a), rdata[0], 64'h0);
        end
        set_idle();
        do_reset();

        // Reset part-way through a clear
        for (int a = 0; a < 64; a++) load_both(a, 64'hDEAD);
        clr_req = 1'b1;
        tick();
        set_idle();
        repeat (10) tick();
        do_reset();
        for (int a = 0; a <= 10; a++) begin
            read_at(a);
            check_eq($sformatf("abort_word%0d", a), rdata[0], (a < 10) ? 64'h0 : 64'hDEAD);
        end
        set_idle();
        tick();
        tick();

        // Out-of-range access on the 48-word instance
        load_both(18, 64'h1818_1818_1818_1818);
        csb = 1'b0; wsb = 1'b0; waddr = 6'd50; raddr = 6'd50; wdata = {$urandom, $urandom};
        wmask = 8'hFF;
        tick();
        read_at(18);
        check_eq("oor_rd_data", rdata[1], 64'h0);
        check_eq("oor_rd_valid", {63'h0, rvalid[1]}, 64'h1);
        set_idle();
        tick();
        check_eq("oor_alias", rdata[1], 64'h1818_1818_1818_1818);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sram_param_bwe.md
SRAM_PARAM_BWE -- requirements
Module: sram_param_bwe

Interface
REQ-001 SHALL provide parameter DATA_W, default 64, the data word width in bits; it must be a multiple of 8.
REQ-002 SHALL provide parameter DEPTH, default 64, the number of words.
REQ-003 SHALL provide parameter ADDR_W, default 6, the address width; DEPTH <= 2**ADDR_W.
REQ-004 SHALL provide parameter OUT_REG, default 0; 1 adds one output pipeline stage.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic on posedge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port csb, input, 1 bit: chip enable, active-low.
REQ-008 SHALL have port wsb, input, 1 bit: write enable, active-low, qualified by csb.
REQ-009 SHALL have port wmask, input, DATA_W/8 bits: byte write enables, active-high; bit i covers wdata[8i+7:8i].
REQ-010 SHALL have port wdata, input, DATA_W bits: write data.
REQ-011 SHALL have port waddr, input, ADDR_W bits: write address.
REQ-012 SHALL have port raddr, input, ADDR_W bits: read address.
REQ-013 SHALL have port clr_req, input, 1 bit: one-cycle request to zero the whole array.
REQ-014 SHALL have port busy, output, 1 bit: high while the clear engine runs.
REQ-015 SHALL have port rdata, output, DATA_W bits: read data.
REQ-016 SHALL have port rvalid, output, 1 bit: one-cycle strobe marking rdata as new.

Function
REQ-017 SHALL, on posedge clk with ~csb & ~wsb & ~busy & waddr<DEPTH, write only the bytes of mem[waddr] whose wmask bit is 1; all other bytes keep their value.
REQ-018 SHALL treat ~csb & ~busy as a read issue, sampling raddr on that edge.
REQ-019 SHALL, with OUT_REG=0, present the read data and pulse rvalid one cycle after the issue edge.
REQ-020 SHALL, with OUT_REG=1, present the read data and pulse rvalid two cycles after the issue edge; back-to-back issues yield back-to-back rvalid.
REQ-021 SHALL hold rdata unchanged when no read completes; rvalid is 0 in such cycles.
REQ-022 SHALL, when a read and a write hit the same address on the same edge, return write-first data: masked bytes from wdata and unmasked bytes from the old word.
REQ-023 SHALL return all-zero data with rvalid=1 for a read with raddr>=DEPTH; a write with waddr>=DEPTH SHALL be dropped.
REQ-024 SHALL implement a clear FSM with states IDLE and CLEAR and an ADDR_W-bit counter clr_cnt.
REQ-025 SHALL, on clr_req=1 in IDLE, go to CLEAR with clr_cnt=0; busy SHALL rise on that same edge.
REQ-026 SHALL, in CLEAR, write zero to mem[clr_cnt] every cycle, increment clr_cnt, and go to IDLE after the write to DEPTH-1; a clear therefore occupies exactly DEPTH cycles.
REQ-027 SHALL ignore csb, wsb and clr_req while busy=1; a clr_req on the edge that returns the FSM to IDLE SHALL also be ignored.
REQ-028 SHALL complete a read issued on the edge on which clr_req is accepted normally, returning pre-clear data.
REQ-029 SHALL provide simulation-only tasks: load(index, data) writing one word and display() printing all DEPTH words in hex; neither is synthesised.

Reset
REQ-030 SHALL, on rst_n=0, immediately (asynchronously) set rdata=0, rvalid=0, busy=0, FSM=IDLE, clr_cnt=0, and clear the pipeline stage.
REQ-031 SHALL not reset memory contents; reset during CLEAR SHALL abort the clear and leave the remaining words unchanged.
REQ-032 SHALL ignore all requests while rst_n=0 and resume normal operation on the first edge after deassertion.

Verification
REQ-033 Masked write: load mem[5]=64'h1111_1111_1111_1111; write waddr=5, wdata=64'hAAAA_BBBB_CCCC_DDDD, wmask=8'h0F; read 5 -> rdata=64'h1111_1111_CCCC_DDDD one cycle later, rvalid=1 for that cycle only.
REQ-034 Read-during-write: with mem[9]=0, write addr 9 with wdata=64'hFF, wmask=8'h01 and read addr 9 on the same edge -> rdata=64'h00000000_000000FF.
REQ-035 Latency with OUT_REG=1: reads of addresses 0,1,2 on consecutive edges -> rvalid high on edges 2,3,4 with data in that order.
REQ-036 Clear: after loading all words with 64'hDEAD, pulse clr_req -> busy high for exactly 64 cycles, a write during busy is dropped, display() shows all zeros.
REQ-037 Reset mid-clear: assert rst_n=0 after 10 clear cycles -> busy=0 and rdata=0 immediately; words 0-9 read 0 and word 10 reads 64'hDEAD.
REQ-038 Out of range: with DEPTH=48, ADDR_W=6, read raddr=50 -> rdata=0 with rvalid=1; a write to address 50 leaves mem[50-32]=mem[18] unchanged.
